// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding and
// default bus widths.
package mem_access_ctrl_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DATA_RD = 2'd2,
    ST_DATA_WR = 2'd3
  } state_e;

  function automatic logic is_read_state(state_e s);
    return (s == ST_FETCH) || (s == ST_DATA_RD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_watchdog.sv
// Per-access wait counter; only compiled when MEM_TIMEOUT_EN is defined.
// Holds at zero while idle, so every access starts counting from zero.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic hs_i,
  output logic expired_o
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!active_i || hs_i) count_d = '0;
    else                   count_d = count_q + 1'b1;
  end

  // Expire on the edge where the count would reach the limit.
  assign expired_o = active_i && !hs_i && ((count_q + 1'b1) == LIMIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch, data load and data store onto one memory port.
// Define MEM_TIMEOUT_EN to add a per-access watchdog and sticky timeout_err_o.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no access; accepts highest-priority request
// ST_FETCH   | readM high, waiting for inputReady (instr)
// ST_DATA_RD | readM high, waiting for inputReady (load)
// ST_DATA_WR | writeM high, bus driven, waiting for ackOutput
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  input  logic                  data_rd_req_i,
  input  logic                  data_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [WORD_SIZE-1:0]  wr_data_i,
  output logic [WORD_SIZE-1:0]  instr_out_o,
  output logic                  instr_valid_o,
  output logic [WORD_SIZE-1:0]  rd_data_out_o,
  output logic                  rd_data_valid_o,
  output logic                  wr_done_o,
  output logic                  busy_o,
  output logic                  readM_o,
  output logic                  writeM_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  inout  wire  [WORD_SIZE-1:0]  data_io,
  input  logic                  inputReady_i,
  input  logic                  ackOutput_i,
  output logic                  timeout_err_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]  instr_q, instr_d;
  logic [WORD_SIZE-1:0]  rd_q, rd_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_done_q, wr_done_d;
  logic                  hs;
  logic                  expired;

  // Only the handshake matching the current access counts.
  assign hs = (is_read_state(state_q) && inputReady_i) ||
              ((state_q == ST_DATA_WR) && ackOutput_i);

`ifdef MEM_TIMEOUT_EN
  logic timeout_err_q;

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .active_i  (state_q != ST_IDLE),
    .hs_i      (hs),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)      timeout_err_q <= 1'b0;
    else if (expired) timeout_err_q <= 1'b1;
  end

  assign timeout_err_o = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expired            = 1'b0;
  assign timeout_err_o      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    instr_d       = instr_q;
    rd_d          = rd_q;
    instr_valid_d = 1'b0;
    rd_valid_d    = 1'b0;
    wr_done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req_i) begin
          state_d = ST_FETCH;
          addr_d  = fetch_addr_i;
        end else if (data_rd_req_i) begin
          state_d = ST_DATA_RD;
          addr_d  = data_addr_i;
        end else if (data_wr_req_i) begin
          state_d = ST_DATA_WR;
          addr_d  = data_addr_i;
          wdata_d = wr_data_i;
        end
      end
      ST_FETCH: begin
        if (hs) begin
          state_d       = ST_IDLE;
          instr_d       = data_io;
          instr_valid_d = 1'b1;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_RD: begin
        if (hs) begin
          state_d    = ST_IDLE;
          rd_d       = data_io;
          rd_valid_d = 1'b1;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_WR: begin
        if (hs) begin
          state_d   = ST_IDLE;
          wr_done_d = 1'b1;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      instr_q       <= '0;
      rd_q          <= '0;
      instr_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      instr_q       <= instr_d;
      rd_q          <= rd_d;
      instr_valid_q <= instr_valid_d;
      rd_valid_q    <= rd_valid_d;
      wr_done_q     <= wr_done_d;
    end
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign readM_o         = is_read_state(state_q);
  assign writeM_o        = (state_q == ST_DATA_WR);
  assign address_o       = busy_o ? addr_q : '0;
  assign data_io         = writeM_o ? wdata_q : {WORD_SIZE{1'bz}};
  assign instr_out_o     = instr_q;
  assign instr_valid_o   = instr_valid_q;
  assign rd_data_out_o   = rd_q;
  assign rd_data_valid_o = rd_valid_q;
  assign wr_done_o       = wr_done_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default 16: data bus and instruction width.
REQ-002 Parameter ADDR_WIDTH, default 16: memory address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: maximum wait cycles per access; used only under MEM_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_req  in  1  level request for an instruction fetch.
REQ-007 fetch_addr  in  ADDR_WIDTH  instruction address.
REQ-008 data_rd_req / data_wr_req  in  1 each  level requests for a data read / data write.
REQ-009 data_addr  in  ADDR_WIDTH  data address.
REQ-010 wr_data  in  WORD_SIZE  store data.
REQ-011 instr_out  out  WORD_SIZE  last fetched instruction, held stable.
REQ-012 instr_valid  out  1  one-cycle pulse when instr_out updates.
REQ-013 rd_data_out  out  WORD_SIZE  last loaded data word, held stable.
REQ-014 rd_data_valid  out  1  one-cycle pulse when rd_data_out updates.
REQ-015 wr_done  out  1  one-cycle pulse on write completion.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 readM / writeM  out  1 each  memory read / write strobes.
REQ-018 address  out  ADDR_WIDTH  memory address.
REQ-019 data  inout  WORD_SIZE  bidirectional memory bus.
REQ-020 inputReady  in  1  memory read data valid.
REQ-021 ackOutput  in  1  memory write accepted.
REQ-022 timeout_err  out  1  sticky access-timeout flag.

Function
REQ-023 States: IDLE, FETCH, DATA_RD, DATA_WR.
REQ-024 In IDLE, request priority: fetch_req > data_rd_req > data_wr_req; the request is accepted at edge k, the state changes at k, and the address is latched at k.
REQ-025 readM = 1 exactly in FETCH or DATA_RD; writeM = 1 exactly in DATA_WR; address = latched address in those states, else 0.
REQ-026 data is driven with latched wr_data only in DATA_WR; otherwise data is high-Z.
REQ-027 FETCH/DATA_RD: on the edge where inputReady = 1, capture data into instr_out / rd_data_out, pulse the matching valid in the following cycle, and return to IDLE.
REQ-028 DATA_WR: on the edge where ackOutput = 1, return to IDLE and pulse wr_done in the following cycle.
REQ-029 Minimum access latency: strobe high from the cycle after acceptance; valid or done arrives one cycle after the handshake.
REQ-030 Back-to-back accesses are separated by exactly one IDLE cycle; a request pending during that cycle is accepted in it.
REQ-031 inputReady and ackOutput are ignored in IDLE and in non-matching states.
REQ-032 instr_out and rd_data_out change only on their own captures; requests changing mid-access do not affect the latched address or data.

Reset
REQ-033 On reset, the next state is IDLE, even mid-access; strobes drop at that edge.
REQ-034 On reset, instr_out, rd_data_out, all pulses, busy and timeout_err are set to 0, and data is high-Z.

Configuration
REQ-035 With MEM_TIMEOUT_EN defined: a wait counter clears on entry to FETCH/DATA_RD/DATA_WR and increments each cycle without handshake.
REQ-036 With MEM_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES: abort to IDLE with no valid/done pulse, and set timeout_err until reset.
REQ-037 Without MEM_TIMEOUT_EN: no counter; accesses wait indefinitely; timeout_err is tied to 0 and the port remains present.

Structure
REQ-038 A shared package/header holds the state encoding constants and the default WORD_SIZE/ADDR_WIDTH values.
REQ-039 The wait counter is a sub-module mem_watchdog, parametrised by TIMEOUT_CYCLES with width $clog2(TIMEOUT_CYCLES+1), and is instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-040 Fetch: fetch_addr=0x0010, memory raises inputReady 3 cycles after readM with data 0x6A05 -> instr_out=0x6A05, one-cycle instr_valid, readM low after the handshake edge.
REQ-041 Simultaneous fetch_req and data_wr_req (addr 0x0020, 0xBEEF): fetch completes first, then one IDLE cycle, then writeM with data=0xBEEF, wr_done after ackOutput; data is high-Z outside DATA_WR.
REQ-042 Load 0x1234 from 0x0030, then fetch 0x5555 -> rd_data_out stays 0x1234 throughout the fetch.
REQ-043 Reset asserted during DATA_RD wait -> readM=0 next cycle, all outputs 0, no rd_data_valid.
REQ-044 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never answers -> abort after 4 wait cycles, timeout_err=1 until reset; without the macro, readM stays high indefinitely.
